// File: rtl/score_note_buffer.sv
// score_note_buffer: decodes PS2 set-2 make codes into note codes, records them
// into an ordered score while in record mode, deletes the last note on request,
// and plays the whole score back at a fixed tempo derived from the 16 Hz tick.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   tick_16hz           one-cycle tempo pulse at 16 Hz
//   key_valid, key_byte PS2 scan byte strobe and data
//   insert_en           record mode level
//   delete_en           delete-last request level (edge-detected)
//   play_en             play-all request level (edge-detected, held during playback)
//   note_out/note_valid note currently sounding/drawn (0/0 when idle)
//   is_full/is_empty    combinational score occupancy flags
//   count               number of stored notes (0..DEPTH)
//   insert_delay_done   one-cycle pulse when an inserted note's audition ends
//   play_done           one-cycle pulse when playback completes
module score_note_buffer #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TICKS_PER_NOTE = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         tick_16hz,
    input  logic                         key_valid,
    input  logic [7:0]                   key_byte,
    input  logic                         insert_en,
    input  logic                         delete_en,
    input  logic                         play_en,
    output logic [3:0]                   note_out,
    output logic                         note_valid,
    output logic                         is_full,
    output logic                         is_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         insert_delay_done,
    output logic                         play_done
);

    localparam int unsigned NW = 4;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_NOTE - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INS_HOLD = 2'd1,
        S_PLAY     = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            brk, brk_nxt;
    logic            ev_valid;
    logic [NW-1:0]   ev_code;
    logic            dec_valid_c;
    logic [NW-1:0]   dec_code_c;
    logic            play_q, del_q;
    logic            play_rise_c, del_rise_c;
    logic [TW-1:0]   tick_cnt, tick_nxt;
    logic [IW-1:0]   rd_idx, rd_nxt;
    logic [CW-1:0]   count_nxt;
    logic [NW-1:0]   note_out_nxt;
    logic            note_valid_nxt;
    logic            ins_done_nxt, play_done_nxt;
    logic            wr_en;
    logic [NW-1:0]   note_mem [DEPTH];

    assign play_rise_c = play_en & ~play_q;
    assign del_rise_c  = delete_en & ~del_q;
    assign is_full     = (count == COUNT_MAX);
    assign is_empty    = (count == '0);

    // PS2 byte decode; the byte following F0 is a break code and is discarded.
    always_comb begin
        dec_code_c  = '0;
        dec_valid_c = 1'b0;
        brk_nxt     = brk;
        if (key_valid) begin
            if (key_byte == 8'hF0) begin
                brk_nxt = 1'b1;
            end else if (key_byte == 8'hE0) begin
                brk_nxt = brk;
            end else if (brk) begin
                brk_nxt = 1'b0;
            end else begin
                case (key_byte)
                    8'h1C:   dec_code_c = 4'd1;
                    8'h1B:   dec_code_c = 4'd2;
                    8'h23:   dec_code_c = 4'd3;
                    8'h2B:   dec_code_c = 4'd4;
                    8'h34:   dec_code_c = 4'd5;
                    8'h33:   dec_code_c = 4'd6;
                    8'h3B:   dec_code_c = 4'd7;
                    8'h42:   dec_code_c = 4'd8;
                    8'h29:   dec_code_c = 4'd15;
                    default: dec_code_c = 4'd0;
                endcase
                dec_valid_c = (dec_code_c != '0);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt      = state;
        tick_nxt       = tick_cnt;
        rd_nxt         = rd_idx;
        count_nxt      = count;
        note_out_nxt   = note_out;
        note_valid_nxt = note_valid;
        ins_done_nxt   = 1'b0;
        play_done_nxt  = 1'b0;
        wr_en          = 1'b0;
        case (state)
            S_IDLE: begin
                if (play_rise_c) begin
                    if (count != '0) begin
                        state_nxt      = S_PLAY;
                        rd_nxt         = '0;
                        tick_nxt       = '0;
                        note_valid_nxt = 1'b1;
                        note_out_nxt   = note_mem[0];
                    end else begin
                        play_done_nxt = 1'b1;
                    end
                end else if (del_rise_c) begin
                    if (count != '0) begin
                        count_nxt = count - CW'(1);
                    end
                end else if (ev_valid && insert_en && !is_full) begin
                    wr_en          = 1'b1;
                    count_nxt      = count + CW'(1);
                    note_out_nxt   = ev_code;
                    note_valid_nxt = 1'b1;
                    tick_nxt       = '0;
                    state_nxt      = S_INS_HOLD;
                end
            end
            S_INS_HOLD: begin
                if (tick_16hz) begin
                    if (tick_cnt == TICK_LAST) begin
                        note_valid_nxt = 1'b0;
                        note_out_nxt   = '0;
                        ins_done_nxt   = 1'b1;
                        state_nxt      = S_IDLE;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            S_PLAY: begin
                if (!play_en) begin
                    // Abort: silent return, no completion pulse.
                    note_valid_nxt = 1'b0;
                    note_out_nxt   = '0;
                    state_nxt      = S_IDLE;
                end else if (tick_16hz) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        if (CW'(rd_idx) == count - CW'(1)) begin
                            note_valid_nxt = 1'b0;
                            note_out_nxt   = '0;
                            play_done_nxt  = 1'b1;
                            state_nxt      = S_IDLE;
                        end else begin
                            rd_nxt       = rd_idx + IW'(1);
                            note_out_nxt = note_mem[rd_idx + IW'(1)];
                        end
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            brk               <= 1'b0;
            ev_valid          <= 1'b0;
            ev_code           <= '0;
            play_q            <= 1'b0;
            del_q             <= 1'b0;
            tick_cnt          <= '0;
            rd_idx            <= '0;
            count             <= '0;
            note_out          <= '0;
            note_valid        <= 1'b0;
            insert_delay_done <= 1'b0;
            play_done         <= 1'b0;
        end else begin
            state             <= state_nxt;
            brk               <= brk_nxt;
            ev_valid          <= dec_valid_c;
            ev_code           <= dec_code_c;
            play_q            <= play_en;
            del_q             <= delete_en;
            tick_cnt          <= tick_nxt;
            rd_idx            <= rd_nxt;
            count             <= count_nxt;
            note_out          <= note_out_nxt;
            note_valid        <= note_valid_nxt;
            insert_delay_done <= ins_done_nxt;
            play_done         <= play_done_nxt;
        end
    end

    // Score storage; contents need no reset since count gates every read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            note_mem[IW'(count)] <= ev_code;
        end
    end

endmodule

// File: doc/score_note_buffer.md
Name: score_note_buffer

Overview:
- Sits between the PS2 keyboard receiver and the tone/VGA note consumers in the composer datapath.
- Decodes PS2 set-2 make codes into note codes and stores the notes entered in record mode in an ordered score buffer.
- Supports deleting the last entered note.
- In play mode, sequences the stored notes out at a fixed tempo derived from the 16 Hz tick.
- Drives the controller handshakes is_full, insert_delay_done and play_done.

Parameters:
DEPTH, 16, score capacity in notes (power of 2; 4 bars x 4 quarter notes)
TICKS_PER_NOTE, 8, 16 Hz ticks each note is held (0.5 s)

Ports:
clock  in  1  system clock (50 MHz); all logic rising-edge
reset  in  1  synchronous, active-high
tick_16hz  in  1  one-clock-wide pulse at 16 Hz, synchronous to clock
key_valid  in  1  one-clock strobe: key_byte holds a new PS2 byte
key_byte  in  8  raw PS2 set-2 scan byte
insert_en  in  1  level; record mode active
delete_en  in  1  level; delete request (edge-detected internally)
play_en  in  1  level; play-all request (edge-detected; must stay high during playback)
note_out  out  4  current note code (0 when idle)
note_valid  out  1  note_out is sounding/drawn
is_full  out  1  count == DEPTH
is_empty  out  1  count == 0
count  out  5  notes stored (0..DEPTH)
insert_delay_done  out  1  one-cycle pulse after an inserted note's audition ends
play_done  out  1  one-cycle pulse after playback completes

Behaviour:
- Reset and clock: reset and clock are as decided (reset synchronous, active-high; clock clock).
- Reset values: note_out=0, note_valid=0, count=0, is_empty=1, is_full=0, both done pulses 0, state IDLE, break flag 0, tick counter 0, edge registers 0. Buffer RAM contents are don't-care.
- Key decode:
  - Byte 0xF0 sets the break flag. The next byte clears it and is discarded.
  - Byte 0xE0 is discarded and does not affect the break flag.
  - Make codes map A=1C->1, S=1B->2, D=23->3, F=2B->4, G=34->5, H=33->6, J=3B->7, K=42->8, Space=29->15 (rest).
  - Any other byte produces no event.
  - Decode is registered: a decoded event is valid 1 cycle after key_valid.
- States: IDLE, INS_HOLD, PLAY.
- IDLE, priority play > delete > insert when events coincide:
  - play_en rising edge with count>0 -> PLAY, rd_idx=0, tick counter=0, note_valid=1, note_out=buf[0] on the next cycle.
  - play_en rising edge with count==0 -> play_done pulses the next cycle; state stays IDLE.
  - delete_en rising edge with count>0 -> count decrements by 1. With count==0 it is a no-op. No done pulse in either case.
  - Decoded note event with insert_en=1 and !is_full -> buf[count]=code, count++, note_out=code, note_valid=1, tick counter=0, go to INS_HOLD.
  - Decoded note event while full -> dropped; no pulse.
  - Decoded note event with insert_en=0 -> ignored.
- INS_HOLD:
  - Each tick increments the tick counter.
  - On the tick where the counter equals TICKS_PER_NOTE-1: note_valid=0, note_out=0, insert_delay_done pulses for 1 cycle, go to IDLE.
  - Key events arriving in INS_HOLD are dropped.
  - insert_en falling does not abort the hold.
- PLAY:
  - Each note is held for exactly TICKS_PER_NOTE tick pulses.
  - On the final tick of a note: if rd_idx==count-1, then note_valid=0, note_out=0, play_done pulses for 1 cycle, go to IDLE; otherwise rd_idx++ and note_out=buf[rd_idx+1].
  - play_en low at any cycle -> abort to IDLE next cycle with note_valid=0, note_out=0 and no play_done.
  - Key, delete and insert inputs are ignored during PLAY.
- Edge detectors update every cycle in all states. A level that is already high on return to IDLE does not retrigger.
- Flags: is_full and is_empty are combinational from count and are valid the cycle after count changes.
- count never wraps: no increment at DEPTH, no decrement at 0.
- Reset asserted in any state returns all outputs to reset values on the next edge, with no done pulse.

Test Plan:
- Make codes and count: reset; insert_en=1; send 1C, then after insert_delay_done send 23 and 42 -> count=3. Each insert shows note_out 1, 3, 8 respectively for 8 ticks, followed by a 1-cycle insert_delay_done.
- Break codes: send F0,1C with insert_en=1 -> no insert (count unchanged); then E0,75 -> no insert; then 1B -> note 2 stored.
- Playback: with score {1,3,8}, raise play_en -> note_out sequence 1,3,8, each note lasting exactly 8 ticks; after the 24th tick, note_valid=0 and play_done is high for 1 cycle.
- Capacity limits: fill 16 notes -> is_full=1; a 17th key produces no pulse and count stays 16. Then 17 delete_en edges -> count=0 and is_empty=1, with no underflow.
- Empty play and abort: play_en edge with count=0 -> play_done pulses the next cycle. With 4 notes, drop play_en during note 2 -> note_valid=0 the next cycle and play_done never pulses.
- Reset and priority: assert reset mid-PLAY -> all outputs at reset values on the next edge, count=0. Assert play_en edge and delete_en edge in the same cycle with count=2 -> PLAY entered and count remains 2.
